// File: rtl/frame_stream_sequencer.sv
// frame_stream_sequencer: schedules the generator's meta-data and frame-data
// streams onto one outbound AXI-Stream. Each frame is MD_BEATS meta-data beats
// followed by FRAME_SIZE/(DW/8) frame-data beats. The data path is a
// zero-latency mux; only the sequencing state and accounting are registered.
module frame_stream_sequencer #(
  parameter int unsigned DW       = 512,
  parameter int unsigned MD_BEATS = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   FRAME_SIZE,
  input  logic [DW-1:0] AXIS_MD_TDATA,
  input  logic          AXIS_MD_TVALID,
  output logic          AXIS_MD_TREADY,
  input  logic [DW-1:0] AXIS_FD_TDATA,
  input  logic          AXIS_FD_TVALID,
  output logic          AXIS_FD_TREADY,
  output logic [DW-1:0] AXIS_OUT_TDATA,
  output logic          AXIS_OUT_TVALID,
  output logic          AXIS_OUT_TUSER,
  output logic          AXIS_OUT_TLAST,
  input  logic          AXIS_OUT_TREADY,
  output logic [31:0]   FRAMES_DONE,
  output logic          SIZE_ERR
);

  localparam int unsigned BPB = DW / 8;
  localparam int unsigned LB  = $clog2(BPB);

  typedef enum logic {
    S_MD = 1'b0,
    S_FD = 1'b1
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [7:0]  r_md_cnt, w_md_cnt_nxt;
  logic [31:0] r_fd_cnt, w_fd_cnt_nxt;
  logic [31:0] r_beats,  w_beats_nxt;
  logic [31:0] r_frames, w_frames_nxt;
  logic        r_size_err, w_size_err_nxt;

  logic [31:0] w_words;
  logic        w_size_bad;
  logic        w_md_hs;
  logic        w_fd_hs;

  // Frame length in beats and its legality, taken from the live FRAME_SIZE
  assign w_words    = FRAME_SIZE >> LB;
  assign w_size_bad = (FRAME_SIZE[LB-1:0] != '0) || (w_words == 32'd0);

  // Transfers only count on the selected source and outside reset
  assign w_md_hs = resetn && (r_state == S_MD) && AXIS_MD_TVALID && AXIS_OUT_TREADY;
  assign w_fd_hs = resetn && (r_state == S_FD) && AXIS_FD_TVALID && AXIS_OUT_TREADY;

  assign FRAMES_DONE = r_frames;
  assign SIZE_ERR    = r_size_err;

  // Sequencing state and accounting registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_MD;
      r_md_cnt   <= 8'd1;
      r_fd_cnt   <= 32'd1;
      r_beats    <= 32'd1;
      r_frames   <= 32'd0;
      r_size_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_cnt   <= w_md_cnt_nxt;
      r_fd_cnt   <= w_fd_cnt_nxt;
      r_beats    <= w_beats_nxt;
      r_frames   <= w_frames_nxt;
      r_size_err <= w_size_err_nxt;
    end
  end

  // Output mux, handshake steering and next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_md_cnt_nxt    = r_md_cnt;
    w_fd_cnt_nxt    = r_fd_cnt;
    w_beats_nxt     = r_beats;
    w_frames_nxt    = r_frames;
    w_size_err_nxt  = r_size_err;
    AXIS_OUT_TDATA  = AXIS_MD_TDATA;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TUSER  = 1'b1;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_MD_TREADY  = 1'b0;
    AXIS_FD_TREADY  = 1'b0;

    case (r_state)
      S_MD: begin
        AXIS_OUT_TDATA  = AXIS_MD_TDATA;
        AXIS_OUT_TVALID = AXIS_MD_TVALID && resetn;
        AXIS_MD_TREADY  = AXIS_OUT_TREADY && resetn;
        AXIS_OUT_TUSER  = 1'b1;
        if (w_md_hs) begin
          // Frame length is frozen on the first meta-data beat of the frame
          if (r_md_cnt == 8'd1) begin
            w_beats_nxt = (w_words == 32'd0) ? 32'd1 : w_words;
            if (w_size_bad) begin
              w_size_err_nxt = 1'b1;
            end
          end
          if (r_md_cnt == 8'(MD_BEATS)) begin
            w_md_cnt_nxt = 8'd1;
            w_fd_cnt_nxt = 32'd1;
            w_state_nxt  = S_FD;
          end else begin
            w_md_cnt_nxt = r_md_cnt + 8'd1;
          end
        end
      end
      S_FD: begin
        AXIS_OUT_TDATA  = AXIS_FD_TDATA;
        AXIS_OUT_TVALID = AXIS_FD_TVALID && resetn;
        AXIS_FD_TREADY  = AXIS_OUT_TREADY && resetn;
        AXIS_OUT_TUSER  = 1'b0;
        AXIS_OUT_TLAST  = (r_fd_cnt == r_beats);
        if (w_fd_hs) begin
          if (r_fd_cnt == r_beats) begin
            w_state_nxt  = S_MD;
            w_frames_nxt = r_frames + 32'd1;
          end else begin
            w_fd_cnt_nxt = r_fd_cnt + 32'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_MD;
      end
    endcase
  end

endmodule

// File: doc/frame_stream_sequencer.md
Name: frame_stream_sequencer

Overview:
- Sits directly downstream of the frame generator. Owns the single outbound AXI-Stream.
- Schedules the generator's two source streams, meta-data (MD) and frame-data (FD), onto that output.
- Per frame: exactly MD_BEATS meta-data beats, then FRAME_SIZE/(DW/8) frame-data beats, with TLAST on the final FD beat.
- Also provides frame accounting and a sticky frame-size error flag for software.

Parameters:
- DW, 512, stream data width in bits; must be a power of 2, at least 64.
- MD_BEATS, 2, meta-data beats emitted ahead of each frame (1..255).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- FRAME_SIZE  in  32  frame size in bytes; sampled once per frame
- AXIS_MD_TDATA  in  DW  meta-data stream data
- AXIS_MD_TVALID  in  1  meta-data valid
- AXIS_MD_TREADY  out  1  meta-data ready
- AXIS_FD_TDATA  in  DW  frame-data stream data
- AXIS_FD_TVALID  in  1  frame-data valid
- AXIS_FD_TREADY  out  1  frame-data ready
- AXIS_OUT_TDATA  out  DW  merged output data
- AXIS_OUT_TVALID  out  1  output valid
- AXIS_OUT_TUSER  out  1  1 = current beat is meta-data, 0 = frame-data
- AXIS_OUT_TLAST  out  1  last beat of frame
- AXIS_OUT_TREADY  in  1  downstream ready
- FRAMES_DONE  out  32  count of frames completed since reset
- SIZE_ERR  out  1  sticky: a sampled FRAME_SIZE was not a multiple of DW/8, or was smaller than DW/8

Behaviour:
- Bytes per beat BPB = DW/8; LB = log2(BPB).
- States: S_MD (reset state) and S_FD.
- Counters:
  - md_cnt: 8 bits, counts MD beats from 1.
  - fd_cnt: 32 bits, counts FD beats from 1.
  - beats: 32 bits, latched frame length in FD beats.
- Datapath is zero-latency pass-through, with no registers on the data path. A beat transfers in the cycle where the selected source's TVALID and AXIS_OUT_TREADY are both 1.
- In S_MD:
  - OUT_TDATA = MD_TDATA, OUT_TVALID = MD_TVALID, MD_TREADY = OUT_TREADY, FD_TREADY = 0, TUSER = 1, TLAST = 0.
- In S_FD:
  - OUT_TDATA = FD_TDATA, OUT_TVALID = FD_TVALID, FD_TREADY = OUT_TREADY, MD_TREADY = 0, TUSER = 0.
  - TLAST = (fd_cnt == beats).
- While resetn = 0: OUT_TVALID, MD_TREADY and FD_TREADY are forced to 0 combinationally.
- Register reset values: state = S_MD, md_cnt = 1, fd_cnt = 1, beats = 1, FRAMES_DONE = 0, SIZE_ERR = 0.
- First MD handshake of a frame (md_cnt == 1):
  - beats <= FRAME_SIZE >> LB, or 1 if that result is 0.
  - SIZE_ERR <= 1 if FRAME_SIZE[LB-1:0] != 0 or (FRAME_SIZE >> LB) == 0.
  - FRAME_SIZE changes after this point have no effect until the next frame.
- Each MD handshake:
  - If md_cnt == MD_BEATS: md_cnt <= 1, state <= S_FD, fd_cnt <= 1.
  - Otherwise md_cnt <= md_cnt + 1.
  - With MD_BEATS = 1, the latch and the transition happen on the same handshake.
- Each FD handshake:
  - If fd_cnt == beats: state <= S_MD and FRAMES_DONE <= FRAMES_DONE + 1 (wraps 0xFFFFFFFF -> 0).
  - Otherwise fd_cnt <= fd_cnt + 1.
- Holding off the wrong source: FD_TVALID asserted during S_MD is held (FD_TREADY = 0), and MD_TVALID asserted during S_FD is held the same way. No data is dropped, no reordering occurs, and no ready depends on the unselected valid.
- Backpressure: when OUT_TREADY = 0, no state or counter changes. Output follows the selected source.
- Reset mid-frame returns to S_MD with md_cnt = 1. The partial frame is abandoned, and the next MD beat starts a new frame.
- SIZE_ERR clears only on reset.

Test Plan (DW=512, BPB=64, MD_BEATS=2 unless stated):
- Basic frame: FRAME_SIZE=256, MD beats A,B then FD beats 1..4, OUT_TREADY=1 -> output A,B,1,2,3,4.
  - TUSER = 1,1,0,0,0,0; TLAST only on beat 4; FRAMES_DONE = 1; SIZE_ERR = 0.
- Ordering hold-off: FD_TVALID=1 from cycle 0, MD_TVALID rises at cycle 3.
  - FD_TREADY = 0 until both MD beats transfer.
  - First output beat is MD; the FD beat is then passed unaltered.
- Backpressure: OUT_TREADY toggles 1,0,1,0 through a 4-beat frame.
  - No beat lost or duplicated; TLAST held stable while stalled on the last beat; counters frozen on stalled cycles.
- Size latch and error:
  - FRAME_SIZE=256 latched, then changed to 128 mid-frame -> 4 FD beats this frame, 2 FD beats next frame.
  - FRAME_SIZE=100 -> beats = 1, SIZE_ERR = 1, still set after a later valid frame.
  - FRAME_SIZE=0 -> beats = 1, SIZE_ERR = 1.
- Reset mid-frame: resetn=0 for 1 cycle after 2 FD beats of a 4-beat frame.
  - All readies and OUT_TVALID = 0 during reset; FRAMES_DONE = 0.
  - Next output beat has TUSER = 1.
- MD_BEATS=1, three back-to-back 1-beat frames (FRAME_SIZE=64) -> output MD,FD,MD,FD,MD,FD with TLAST on each FD; FRAMES_DONE = 3.
